// File: rtl/relu_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | relu_layer_sequencer: streams column readout words through the shared      |
// | ReLU stage layer by layer into a registered valid/ready output.  Rev 1.0   |
// +----------------------------------------------------------------------------+
module relu_layer_sequencer #(
  parameter int N_COL = 8,
  parameter int DW    = 6,
  parameter int LW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LW-1:0]        num_layers,
  input  logic [(1<<LW)-1:0]   relu_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 act_en,
  output logic [DW-1:0]        act_data,
  input  logic [DW-1:0]        act_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic [LW-1:0]        layer_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int MW = 1 << LW;
  localparam logic [CW-1:0] c_last_col = CW'(N_COL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [LW-1:0]   r_layer;
  logic [LW-1:0]   r_num_layers;
  logic [MW-1:0]   r_mask;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_last_col;
  logic            w_last_layer;
  logic            w_out_hs;

  always_comb begin
    w_in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    w_accept     = in_valid && w_in_ready;
    w_last_col   = (r_col == c_last_col);
    w_last_layer = (r_layer == (r_num_layers - LW'(1)));
    w_out_hs     = r_out_valid && out_ready;
  end

  // Abort wins over every other transition, including a start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = (num_layers != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (w_accept && w_last_col && w_last_layer) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_layer      <= '0;
      r_num_layers <= '0;
      r_mask       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else if (abort) begin
      r_col       <= '0;
      r_layer     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && (num_layers != '0)) begin
            r_num_layers <= num_layers;
            r_mask       <= relu_mask;
            r_col        <= '0;
            r_layer      <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_out_data  <= act_out;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_col;
            if (w_last_col) begin
              r_col <= '0;
              // The final layer index is kept visible after the run ends.
              if (!w_last_layer) begin
                r_layer <= r_layer + LW'(1);
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign act_en    = w_in_ready && r_mask[r_layer];
  assign act_data  = in_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign layer_idx = r_layer;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_relu_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_relu_layer_sequencer: randomized scoreboard bench with a behavioural    |
// | ReLU stage and per-word reference model.  Rev 1.0                           |
// +----------------------------------------------------------------------------+
module tb_relu_layer_sequencer;

  localparam int N_COL = 8;
  localparam int DW    = 6;
  localparam int LW    = 4;
  localparam int MW    = 1 << LW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [LW-1:0] num_layers;
  logic [MW-1:0] relu_mask;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          act_en;
  logic [DW-1:0] act_data;
  logic [DW-1:0] act_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          done;

  relu_layer_sequencer #(.N_COL(N_COL), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_layers(num_layers), .relu_mask(relu_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .act_en(act_en), .act_data(act_data), .act_out(act_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .layer_idx(layer_idx), .busy(busy), .done(done)
  );

  // Activation stage: offset-binary ReLU, codes below mid-scale clamp to zero.
  assign act_out = act_en ? (act_data[DW-1] ? act_data : '0) : act_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            last_hs_cyc = 0;
  bit            mon_skip = 1'b1;
  logic [MW-1:0] m_mask;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] ref_act(input logic [DW-1:0] x, input bit en);
    if (!en) return x;
    return (x >= 6'd32) ? x : '0;
  endfunction

  function automatic logic [DW-1:0] dir_word(input int k);
    case (k)
      0:       return 6'h25;
      1:       return 6'h05;
      8:       return 6'h05;
      9:       return 6'h25;
      default: return DW'($urandom);
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  bit            hold = 1'b0;
  logic [DW-1:0] held;
  always @(negedge clk) begin
    #2;
    if (mon_skip || !rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk(out_valid == 1'b1, "hold_valid", out_valid, 1);
        chk(out_data == held, "hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_output", out_data, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(out_data == e.d, "out_data", out_data, e.d);
          chk(out_last == e.last, "out_last", out_last, e.last);
          last_hs_cyc = cyc;
        end
      end
      hold = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
    chk(layer_idx == '0, {tag, "_layer_idx"}, layer_idx, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(done == 1'b0, {tag, "_done"}, done, 0);
    chk(act_en == 1'b0, {tag, "_act_en"}, act_en, 0);
    chk(out_last == 1'b0, {tag, "_out_last"}, out_last, 0);
  endtask

  // stop_kind: 1 = abort when stop_at words accepted, 2 = async reset there.
  task automatic run_layers(input int nl, input logic [MW-1:0] mask, input int rmode,
                            input bit directed, input int stop_at, input int stop_kind,
                            input int restart_at);
    int total = nl * N_COL;
    int cnt = 0;
    bit seen = 1'b0;
    bit restarted = 1'b0;
    bit stop;
    @(negedge clk);
    start = 1'b1; num_layers = LW'(nl); relu_mask = mask; m_mask = mask;
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0; mon_skip = 1'b0;
    @(negedge clk);
    start = 1'b0; num_layers = LW'($urandom); relu_mask = MW'($urandom);
    if (nl == 0) begin
      #1;
      chk(done == 1'b1, "zero_done", done, 1);
      chk(busy == 1'b0, "zero_busy", busy, 0);
      chk(out_valid == 1'b0, "zero_out_valid", out_valid, 0);
      @(negedge clk); #1;
      chk(done == 1'b0, "zero_done_end", done, 0);
      chk(busy == 1'b0, "zero_busy_end", busy, 0);
      return;
    end
    for (int g = 0; g < 400 && !seen; g++) begin
      start = 1'b0; abort = 1'b0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((g % 4) == 0) || ((g % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      stop = (cnt == stop_at);
      if (cnt < total) begin
        in_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = directed ? dir_word(cnt) : DW'($urandom);
      end else begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end
      if (cnt == restart_at && !restarted) begin
        start = 1'b1; num_layers = '1; relu_mask = MW'($urandom); restarted = 1'b1;
      end
      if (stop && stop_kind == 1) begin
        abort = 1'b1; out_ready = 1'b0;
      end
      #1;
      if (stop) begin
        mon_skip = 1'b1;
        if (stop_kind == 1) begin
          @(negedge clk);
          abort = 1'b0; in_valid = 1'b0; #1;
          check_idle_outputs("abort");
          for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk(done == 1'b0, "abort_no_done", done, 0);
          end
        end else begin
          #2 rst_n = 1'b0;
          #1;
          check_idle_outputs("reset");
          chk(out_data == '0, "reset_out_data", out_data, 0);
          @(negedge clk);
          in_valid = 1'b0; rst_n = 1'b1;
        end
        q.delete();
        return;
      end
      chk(busy == (cnt < total) || busy == 1'b1, "busy", busy, 1);
      chk(in_ready == ((cnt < total) && (!out_valid || out_ready)), "in_ready",
          in_ready, (cnt < total) && (!out_valid || out_ready));
      chk(act_en == (in_ready && m_mask[cnt / N_COL]), "act_en", act_en,
          in_ready && m_mask[cnt / N_COL]);
      if (in_valid && in_ready) begin
        exp_t e;
        e.d    = ref_act(in_data, m_mask[cnt / N_COL]);
        e.last = ((cnt % N_COL) == N_COL - 1);
        q.push_back(e);
        cnt++;
      end
      if (done) begin
        seen = 1'b1;
        chk(cnt == total, "done_count", cnt, total);
        chk(q.size() == 0, "done_queue_empty", q.size(), 0);
        chk(cyc == last_hs_cyc + 1, "done_latency", cyc - last_hs_cyc, 1);
        chk(layer_idx == LW'(nl - 1), "final_layer_idx", layer_idx, nl - 1);
      end
      if (!seen) @(negedge clk);
    end
    if (!seen) begin
      chk(1'b0, "done_timeout", cnt, total);
      q.delete();
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk(done == 1'b0, "done_one_cycle", done, 0);
    chk(busy == 1'b0, "idle_after_done", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_layers = '0; relu_mask = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    chk(out_data == '0, "rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_layers(2, 16'h0001, 0, 1'b1, -1, 0, -1);
    run_layers(1, MW'($urandom), 1, 1'b0, -1, 0, -1);
    run_layers(2, MW'($urandom), 1, 1'b0, -1, 0, -1);
    run_layers(0, MW'($urandom), 0, 1'b0, -1, 0, -1);
    run_layers(3, MW'($urandom), 2, 1'b0, 11, 1, -1);
    run_layers(2, MW'($urandom), 2, 1'b0, -1, 0, -1);
    run_layers(2, MW'($urandom), 2, 1'b0, 5, 2, -1);
    run_layers(1, MW'($urandom), 2, 1'b0, -1, 0, 3);
    for (int r = 0; r < 6; r++) begin
      run_layers($urandom_range(1, 4), MW'($urandom), 2, 1'b0, -1, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
